// File: rtl/bus_pkg.sv
// Shared definitions for bus initiators and monitors on the peripheral bus.
// The widths fall back to 32 bits when the shared const_defines.v is not loaded first.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package bus_pkg;

    localparam int AHB_AW = `AHB_ADDR_WIDTH;
    localparam int AHB_DW = `AHB_DATA_WIDTH;

    typedef enum logic [2:0] {
        BUS_IDLE = 3'd0,
        BUS_SEL  = 3'd1,
        BUS_ADDR = 3'd2,
        BUS_DATA = 3'd3,
        BUS_WAIT = 3'd4,
        BUS_RESP = 3'd5
    } bus_mst_state_t;

endpackage

// File: rtl/ahb_bus_master.sv
// Single-outstanding initiator: core load/store -> select/address/data beats,
// then waits for hready (or an optional timeout) and returns one response pulse.
module ahb_bus_master
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [`AHB_ADDR_WIDTH-1:0] req_addr,
    input  logic [`AHB_DATA_WIDTH-1:0] req_wdata,
    output logic                       rsp_valid,
    output logic [`AHB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       hsel,
    output logic                       hwrite,
    output logic [`AHB_ADDR_WIDTH-1:0] haddr,
    output logic [`AHB_DATA_WIDTH-1:0] hwdata,
    input  logic                       hready,
    input  logic                       hresp,
    input  logic [`AHB_DATA_WIDTH-1:0] hrdata
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TO_EN  = (TIMEOUT_CYCLES != 0);

    bus_mst_state_t              state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        write_q, write_d;
    logic [`AHB_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [`AHB_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [`AHB_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                        err_q, err_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BUS_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            BUS_IDLE: begin
                if (req_valid) begin
                    state_d = BUS_SEL;
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            BUS_SEL: state_d = BUS_ADDR;
            BUS_ADDR: state_d = write_q ? BUS_DATA : BUS_WAIT;
            BUS_DATA: state_d = BUS_WAIT;
            BUS_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // hready takes priority over a timeout landing in the same cycle
                if (hready) begin
                    state_d = BUS_RESP;
                    err_d   = hresp;
                    rdata_d = (!write_q && !hresp) ? hrdata : '0;
                end else if (TO_EN && (cnt_d == TO_LIM)) begin
                    state_d = BUS_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            BUS_RESP: state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    assign req_ready = (state_q == BUS_IDLE);
    assign busy      = (state_q != BUS_IDLE);
    assign hsel      = (state_q == BUS_SEL);
    assign hwrite    = (state_q == BUS_SEL) & write_q;
    assign haddr     = (state_q == BUS_ADDR) ? addr_q : '0;
    assign hwdata    = (state_q == BUS_DATA) ? wdata_q : '0;
    assign rsp_valid = (state_q == BUS_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/ahb_bus_master.md
# ahb_bus_master

Single-outstanding bus initiator that turns a simple load/store request from the core's memory stage into the codebase's three-beat peripheral bus sequence (select beat, address beat, write-data beat), then waits for `hready` and returns read data or an error. It sits between the core LSU and peripheral slaves such as the UART top. Those slaves handle only one transaction at a time and may stall for thousands of cycles, for example while a UART read completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 0: maximum number of WAIT cycles before the transaction is aborted with an error; 0 disables the timeout.
- `CNT_W`, default 32: width of the WAIT-cycle counter; must satisfy `TIMEOUT_CYCLES < 2**CNT_W`.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  `AHB_ADDR_WIDTH`  target address.
- `req_wdata`  in  `AHB_DATA_WIDTH`  store data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  `AHB_DATA_WIDTH`  load data; 0 on a store or on an error.
- `rsp_err`  out  1  qualifies `rsp_valid`; set on `hresp` or on timeout.
- `busy`  out  1  high in every state except IDLE.
- `hsel`, `hwrite`  out  1 each  select beat.
- `haddr`  out  `AHB_ADDR_WIDTH`  address beat.
- `hwdata`  out  `AHB_DATA_WIDTH`  data beat.
- `hready`, `hresp`  in  1 each  slave completion and error.
- `hrdata`  in  `AHB_DATA_WIDTH`  slave read data.

## Operation
- FSM states are IDLE, SEL, ADDR, DATA, WAIT, RESP.
- Handshake: a request is accepted on the edge where `req_valid & req_ready` is high. On that edge `req_write`, `req_addr` and `req_wdata` are latched.
- IDLE → SEL on acceptance.
- SEL: `hsel`=1 and `hwrite`=latched write bit; `haddr` and `hwdata` are 0. Always moves to ADDR.
- ADDR: `haddr`=latched address; `hsel`=0 and `hwrite`=0. Moves to DATA on a store, or to WAIT on a load.
- DATA: `hwdata`=latched data; `haddr`=0. Always moves to WAIT.
- WAIT: every bus output is 0, and the WAIT counter increments each cycle. Exit rules, in priority order:
  - `hready`=1 → RESP. `hresp` is sampled into `rsp_err`. `hrdata` is sampled into `rsp_rdata` only if the transaction is a load and `hresp`=0.
  - Counter reaches `TIMEOUT_CYCLES` (when nonzero) → RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - `hready` and the timeout occurring in the same cycle: `hready` wins.
- RESP: `rsp_valid`=1 for exactly one cycle. Always moves to IDLE.
- `rsp_rdata` and `rsp_err` hold their values until the next RESP.
- A new request arriving while `busy` is high is not accepted (`req_ready`=0); the core must hold the request until it is accepted.
- `hready` and `hresp` are ignored outside WAIT.
- Reset asserted mid-transaction: outputs clear immediately and the FSM goes to IDLE. The transaction is dropped and no response is generated.

## Timing
- Reset values: all outputs 0, except `req_ready`=1. State is IDLE and the counter is 0.
- All outputs are registered or decoded from state registers; no input-to-output combinational path exists.
- Latency, with acceptance at edge 0 and `hready` already high:
  - Load: SEL in cycle 1, ADDR in cycle 2, WAIT in cycle 3, `rsp_valid` in cycle 4.
  - Store: SEL in cycle 1, ADDR in cycle 2, DATA in cycle 3, WAIT in cycle 4, `rsp_valid` in cycle 5.
  - Each additional cycle with `hready` low adds exactly one cycle.
- `req_ready` returns to 1 in the cycle after RESP. The fastest back-to-back rate is one load every 5 cycles or one store every 6 cycles.
- Timeout: with `TIMEOUT_CYCLES`=N and `hready` held low, RESP is entered after exactly N WAIT cycles.

## Structure
- Bus widths come from the shared `const_defines.v` macros `AHB_ADDR_WIDTH` and `AHB_DATA_WIDTH`.
- The state encoding is placed in a shared package, `bus_pkg`, as `bus_mst_state_t`, so that monitors and the future DMA initiator can reuse it.
- The design is a single module with no sub-modules; the timeout counter is inline.

## Test plan
- Store to 0x30F0F0F0 with data 0x12345678, `hready` tied to 1:
  - `hsel`=1 and `hwrite`=1 in cycle 1, `haddr`=0x30F0F0F0 in cycle 2, `hwdata`=0x12345678 in cycle 3.
  - `rsp_valid`=1 with `rsp_err`=0 in cycle 5.
- Load from 0x30F0F0F0, `hready` low for 40 cycles, then `hready`=1 with `hrdata`=0xF6CCAAE7:
  - `hwrite`=0 and no data beat.
  - `rsp_valid` pulses with `rsp_rdata`=0xF6CCAAE7 exactly 1 cycle after `hready` is sampled.
- Load with `hready`=1 and `hresp`=1 → `rsp_err`=1 and `rsp_rdata`=0.
- With `TIMEOUT_CYCLES`=16 and `hready` stuck at 0:
  - `rsp_err`=1 after exactly 16 WAIT cycles.
  - A following store then completes normally.
- `req_valid` held high for three back-to-back requests → only one is accepted per cycle where `req_ready`=1, and accepted requests are spaced 5 or 6 cycles apart (load or store).
- `rstn` pulsed low during WAIT of a store → all outputs 0 immediately, no `rsp_valid` pulse, `req_ready`=1 after release.
